// File: rtl/mux_rr_if.sv
// Handshake bundle between N producers, the registered selector and one consumer.
// The producer/consumer side uses master; the selector uses slave.
interface mux_rr_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  parameter int SEL_W      = $clog2(NUM_CH)
);
  logic                         mode;
  logic [SEL_W-1:0]             sel;
  logic [NUM_CH-1:0]            in_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]            in_ready;
  logic                         out_valid;
  logic [DATA_WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]             out_ch;
  logic                         out_ready;

  modport master (
    output mode, sel, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, sel, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );
endinterface

// File: rtl/mux_rr_stage.sv
// N-channel registered selector: fixed-select or round-robin grant feeding a
// single output register with valid/ready handshakes on both sides.
module mux_rr_stage #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 4,
  localparam int SEL_W     = $clog2(NUM_CH)
) (
  input  logic      clk,
  input  logic      rst_n,
  mux_rr_if.slave   bus
);

  logic [DATA_WIDTH-1:0] chan [NUM_CH];

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0]      out_ch_q,    out_ch_d;
  logic [SEL_W-1:0]      last_q,      last_d;

  logic [NUM_CH-1:0]     grant;
  logic [SEL_W-1:0]      grant_idx;
  logic [SEL_W-1:0]      idx;
  logic                  found;
  logic                  load_en;
  logic                  xfer;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      chan[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Grant: one-hot or zero. Round-robin scans last+1 upward; the last step
  // (k == NUM_CH) wraps back to last itself, so it has lowest priority.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    found     = 1'b0;
    if (!bus.mode) begin
      grant[bus.sel] = bus.in_valid[bus.sel];
      grant_idx      = bus.sel;
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        idx = last_q + SEL_W'(k);
        if (!found && bus.in_valid[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          grant_idx  = idx;
        end
      end
    end
  end

  assign load_en = !out_valid_q || bus.out_ready;
  assign xfer    = load_en && (grant != '0);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    last_d      = last_q;
    if (load_en) begin
      out_valid_d = xfer;
    end
    if (xfer) begin
      out_data_d = chan[grant_idx];
      out_ch_d   = grant_idx;
      if (bus.mode) begin
        last_d = grant_idx;
      end
    end
  end

  // Output register stage; pointer resets to NUM_CH-1 so ch0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      last_q      <= SEL_W'(NUM_CH - 1);
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      last_q      <= last_d;
    end
  end

  assign bus.in_ready  = grant & {NUM_CH{load_en & rst_n}};
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_stage.sv
// Directed bench for mux_rr_stage (NUM_CH=4, DATA_WIDTH=8).
module tb_mux_rr_stage;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mux_rr_if #(.DATA_WIDTH(8), .NUM_CH(4)) bus ();

  mux_rr_stage #(.DATA_WIDTH(8), .NUM_CH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = '0;
    bus.in_valid  = '0;
    bus.in_data   = 32'h44332211;
    bus.out_ready = 1'b0;
    step();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    rst_n        = 1'b0;
    bus.mode     = 1'b1;
    bus.in_valid = 4'b1111;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", bus.out_valid); end
    tests++;
    if (bus.out_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", bus.out_data); end
    tests++;
    if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready: got %b expected 0000", bus.in_ready); end
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 4'b0001) begin fails++; $display("FAIL reset_first_grant: got %b expected 0001", bus.in_ready); end
    step();
    step();
    // Now holding ch1; assert reset asynchronously mid-cycle.
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'd1) begin
      fails++; $display("FAIL reset_pre_hold: got v=%b ch=%0d expected v=1 ch=1", bus.out_valid, bus.out_ch);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h00 || bus.out_ch !== 2'd0) begin
      fails++; $display("FAIL reset_async: got v=%b d=%h ch=%0d expected v=0 d=00 ch=0",
                        bus.out_valid, bus.out_data, bus.out_ch);
    end
    #1;
    rst_n = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 4'b0001) begin fails++; $display("FAIL reset_regrant: got %b expected 0001", bus.in_ready); end
  endtask

  task automatic test_fixed();
    do_reset();
    bus.mode      = 1'b0;
    bus.sel       = 2'd2;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 4'b0100) begin fails++; $display("FAIL fixed_in_ready: got %b expected 0100", bus.in_ready); end
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h33 || bus.out_ch !== 2'd2) begin
      fails++; $display("FAIL fixed_out: got v=%b d=%h ch=%0d expected v=1 d=33 ch=2",
                        bus.out_valid, bus.out_data, bus.out_ch);
    end
    bus.mode = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 4'b0001) begin fails++; $display("FAIL fixed_ptr_hold: got %b expected 0001", bus.in_ready); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d;
    do_reset();
    bus.mode      = 1'b1;
    bus.in_valid  = 4'b1111;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_d = 8'h11 * 8'(i % 4 + 1);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_ch !== 2'(i % 4) || bus.out_data !== exp_d) begin
        fails++; $display("FAIL rr_seq[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                          i, bus.out_valid, bus.out_ch, bus.out_data, i % 4, exp_d);
      end
    end
    // Last loaded was ch1; no valid input drains the register but keeps data.
    bus.in_valid = 4'b0000;
    step();
    tests++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 8'h22 || bus.out_ch !== 2'd1) begin
      fails++; $display("FAIL rr_bubble: got v=%b d=%h ch=%0d expected v=0 d=22 ch=1",
                        bus.out_valid, bus.out_data, bus.out_ch);
    end
  endtask

  task automatic test_sparse();
    logic [1:0] exp_ch [3];
    exp_ch[0] = 2'd3;
    exp_ch[1] = 2'd1;
    exp_ch[2] = 2'd3;
    do_reset();
    bus.mode      = 1'b1;
    bus.in_valid  = 4'b0010;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (bus.in_ready !== (4'b0001 << exp_ch[i])) begin
        fails++; $display("FAIL sparse_ready[%0d]: got %b expected ch%0d", i, bus.in_ready, exp_ch[i]);
      end
      step();
      tests++;
      if (bus.out_ch !== exp_ch[i] || bus.out_valid !== 1'b1) begin
        fails++; $display("FAIL sparse_out[%0d]: got ch=%0d v=%b expected ch=%0d v=1",
                          i, bus.out_ch, bus.out_valid, exp_ch[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.mode      = 1'b1;
    bus.in_valid  = 4'b0010;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b expected 0000", i, bus.in_ready); end
      step();
      tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h22 || bus.out_ch !== 2'd1) begin
        fails++; $display("FAIL bp_hold[%0d]: got v=%b d=%h ch=%0d expected v=1 d=22 ch=1",
                          i, bus.out_valid, bus.out_data, bus.out_ch);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_ready: got %b expected 0100", bus.in_ready); end
    step();
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h33 || bus.out_ch !== 2'd2) begin
      fails++; $display("FAIL bp_pop_push: got v=%b d=%h ch=%0d expected v=1 d=33 ch=2",
                        bus.out_valid, bus.out_data, bus.out_ch);
    end
  endtask

  task automatic test_mode_switch();
    do_reset();
    bus.mode      = 1'b1;
    bus.in_valid  = 4'b0001;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    bus.mode      = 1'b0;
    bus.sel       = 2'd3;
    bus.in_valid  = 4'b1111;
    #1;
    tests++;
    if (bus.in_ready !== 4'b0000) begin fails++; $display("FAIL ms_bp_ready: got %b expected 0000", bus.in_ready); end
    step();
    tests++;
    if (bus.out_data !== 8'h11 || bus.out_ch !== 2'd0 || bus.out_valid !== 1'b1) begin
      fails++; $display("FAIL ms_held: got v=%b d=%h ch=%0d expected v=1 d=11 ch=0",
                        bus.out_valid, bus.out_data, bus.out_ch);
    end
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 4'b1000) begin fails++; $display("FAIL ms_fixed_ready: got %b expected 1000", bus.in_ready); end
    step();
    tests++;
    if (bus.out_data !== 8'h44 || bus.out_ch !== 2'd3) begin
      fails++; $display("FAIL ms_fixed_load: got d=%h ch=%0d expected d=44 ch=3", bus.out_data, bus.out_ch);
    end
    bus.mode = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 4'b0010) begin fails++; $display("FAIL ms_rr_resume: got %b expected 0010", bus.in_ready); end
    step();
    tests++;
    if (bus.out_data !== 8'h22 || bus.out_ch !== 2'd1) begin
      fails++; $display("FAIL ms_rr_load: got d=%h ch=%0d expected d=22 ch=1", bus.out_data, bus.out_ch);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_sparse();
    test_backpressure();
    test_mode_switch();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mux_rr_stage.md
Name: mux_rr_stage

Overview:
- Parametrised successor to the 4:1 bit-sliced mux: an N-channel, W-bit registered selector with per-channel valid/ready handshakes.
- Two modes: fixed select (sel, same semantics as the combinational mux) and round-robin arbitration among valid channels.
- One output register stage. Sits between multiple producers and a single consumer in the FPGA logic-design datapath.

Parameters:
- DATA_WIDTH, 8, bit width of each channel and of out_data.
- NUM_CH, 4, number of input channels; power of 2, range 2..16.
- SEL_W, $clog2(NUM_CH), width of sel and out_ch; derived, do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = fixed select via sel; 1 = round-robin.
- sel  input  SEL_W  channel selected in fixed mode; ignored in round-robin mode.
- in_valid  input  NUM_CH  per-channel data valid.
- in_data  input  NUM_CH*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  NUM_CH  per-channel accept; combinational.
- out_valid  output  1  output register holds data.
- out_data  output  DATA_WIDTH  registered selected data.
- out_ch  output  SEL_W  index of the channel that supplied out_data.
- out_ready  input  1  consumer accepts out_data.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, round-robin pointer last=NUM_CH-1, so ch0 has top priority after reset. Reset asserted mid-transfer discards the held word. in_ready is 0 while rst_n=0.
- Load enable: load_en = !out_valid | out_ready. This is a full-throughput pipe with no bubbles when out_ready stays high.
- Grant (combinational, one-hot or zero):
  - mode=0: grant[sel] = in_valid[sel]; all other grants are 0.
  - mode=1: grant goes to the first i with in_valid[i]=1, scanning (last+1) mod NUM_CH upward with wrap-around.
  - No valid candidate gives grant=0.
- in_ready[i] = grant[i] & load_en. Transfer on channel i occurs when in_valid[i] & in_ready[i] at a rising edge.
- On a transfer: out_data <= channel data, out_ch <= i, out_valid <= 1. The pointer updates (last <= i) in mode=1 only; in mode=0 the pointer holds.
- If load_en=1 and there is no transfer: out_valid <= 0, and out_data/out_ch hold their last values.
- Backpressure: while out_valid=1 and out_ready=0, out_data/out_ch/out_valid stay stable and all in_ready=0.
- Latency: 1 cycle from accepted input to out_valid.
- Simultaneous pop and push (out_valid=1, out_ready=1, grant≠0): the new word replaces the old in the same edge.
- Mode or sel change: takes effect on the next grant evaluation. It never alters a word already held in the output register.
- Fairness (mode=1, all channels valid, out_ready=1): grants cycle 0,1,…,NUM_CH-1,0,… A channel waits at most NUM_CH-1 transfers.
- Producers must hold in_data stable while in_valid=1 and in_ready=0. The block does not check this.

Test Plan:
- Reset: rst_n=0 asserted asynchronously mid-cycle with out_valid=1 -> out_valid=0, out_data=0, out_ch=0 immediately. After release, with all channels valid in mode=1, the first grant is ch0.
- Fixed mode (NUM_CH=4, W=8): mode=0, sel=2, in_data={D:0x44,C:0x33,B:0x22,A:0x11}, all valid, out_ready=1 -> next cycle out_data=0x33, out_ch=2. Only in_ready[2]=1; the pointer is unchanged.
- Round-robin: mode=1, all valid, out_ready=1 for 6 cycles -> out_ch sequence 0,1,2,3,0,1 with one word per cycle and no bubbles.
- Sparse round-robin: valid={ch3,ch1}, last=1 -> grant ch3; next grant ch1 (wrap-around); then ch3.
- Backpressure: out_valid=1 with 0x22/ch1, out_ready=0 for 3 cycles -> out_data=0x22 and out_ch=1 stable, in_ready=0. On out_ready=1 with ch2 valid, ch2 loads in the same edge.
- Mode switch: in mode=1 with last=0, a word held under backpressure; switch to mode=0, sel=3 -> held word unchanged, next load is from ch3. Switch back to mode=1 -> scan resumes from ch1.
